seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment display controller; successor to the fixed 8-digit, counter-indexed scan in the board top level.
- Scans DIGITS digits from a tear-free double-buffered data register.
- Adds a load/ready handshake, per-digit enables, decimal points, a PWM brightness control and a frame tick.
- Sits in the board top level between confreg-style numeric data and the AN/A2G/DP pins.

Parameters:
- DIGITS, 8: number of digits scanned; legal range 1..16.
- SCAN_DIV, 32768: clk cycles each digit stays selected; minimum 2.
- PWM_BITS, 4: width of the brightness control and the PWM counter.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset; synchronous, active-low.
- load  input  1  request to capture data/dp_in; accepted only when ready=1.
- ready  output  1  high when the pending buffer is empty.
- data  input  4*DIGITS  hex nibbles; digit i = data[4i+3:4i].
- dp_in  input  DIGITS  decimal point per digit, 1 = lit.
- digit_en  input  DIGITS  live (unbuffered) per-digit enable.
- brightness  input  PWM_BITS  live duty control.
- an  output  DIGITS  digit anodes, active-low, one-hot-low.
- seg  output  7  segments, active-low; bit6=g ... bit0=a.
- dp  output  1  decimal point, active-low.
- frame_tick  output  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (resetn=0 at a clk edge) sets:
  - prescaler=0, index=0, pwm_cnt=0.
  - display and pending registers = 0; pending_valid=0.
  - ready=1, an=all ones, seg=7'h7F, dp=1, frame_tick=0.
- Reset mid-operation discards any pending load.
- Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and index advances; index wraps from DIGITS-1 to 0.
- Frame boundary is the cycle in which index wraps to 0. In the following cycle, frame_tick=1 for exactly one cycle.
- Handshake:
  - load && ready: pending<=data/dp_in, pending_valid<=1, ready<=0 next cycle.
  - load while ready=0: ignored; no overwrite.
- Display update:
  - At a frame boundary with pending_valid=1: display<=pending, pending_valid<=0, ready=1 next cycle.
  - A load accepted in the boundary cycle itself is applied at the following boundary, never the current one.
- pwm_cnt increments every clk and wraps freely.
- Lit condition for the current digit: digit_en[index]=1 AND (brightness == all ones OR pwm_cnt < brightness). brightness=0 keeps the display dark.
- Output registers, 1 cycle latency from index/pwm state:
  - Lit: an = ~(1<<index); seg = decode(display nibble); dp = ~display_dp[index].
  - Not lit: an = all ones, seg=7'h7F, dp=1.
  - A disabled digit still consumes its scan slot.
- decode, active-low, 0..F = 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
- Arithmetic widths:
  - prescaler: $clog2(SCAN_DIV) bits.
  - index: $clog2(DIGITS) bits, minimum 1.
- DIGITS=1: index is constant 0, and frame_tick fires every SCAN_DIV cycles.

Optional Feature:
- Macro: SEG7_LZB_EN.
- Defined: leading-zero blanking. Starting from the most significant digit, display nibbles equal to 0 with dp bit 0 are treated as unlit, stopping at the first non-zero nibble or set dp. Digit 0 is never blanked, so value 0 shows "0". Blanking is evaluated on the display register.
- Undefined: all enabled digits are shown, including leading zeros.

Test Plan:
- Bench configuration: DIGITS=4, SCAN_DIV=4, PWM_BITS=4, brightness=4'hF, digit_en=4'hF.
- Reset release with data=0 and no load -> an cycles E,D,B,7, each held 4 cycles; seg=40 in every slot; frame_tick pulses every 16 cycles; ready=1.
- load=1 with data=16'h12AF, dp_in=4'b0100, mid-frame -> ready=0 next cycle. Old digits shown until the frame boundary. Next frame shows seg 0E,08,24,79 on an E,D,B,7, dp=0 only while an=B. ready=1 one cycle after the boundary.
- Second load while ready=0 with data=16'hFFFF -> ignored; display shows 12AF after the boundary.
- Load asserted in the boundary cycle -> value appears one frame later, not at the current boundary.
- brightness=4 -> each digit lit on 4 of 16 pwm phases. brightness=0 -> an stays all ones. digit_en=4'b1011 -> an never 4'hB; slot timing unchanged.
- With SEG7_LZB_EN defined, data=16'h0050, dp_in=0 -> digits 3 and 2 dark, digits 1 and 0 show 5 and 0. Without the macro -> 0,0,5,0 all shown.
- resetn=0 for one cycle while pending_valid=1 -> outputs return to reset values; pending is lost; display shows 0 afterwards.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a double-buffered digit register, load/ready
// handshake, per-digit enables, PWM brightness and a frame tick. SEG7_LZB_EN adds leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 32768,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  output logic                  ready,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [PreW-1:0]     pre_q;
  logic [IdxW-1:0]     idx_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic [4*DIGITS-1:0] disp_data_q, pend_data_q;
  logic [DIGITS-1:0]   disp_dp_q, pend_dp_q;
  logic                pend_valid_q;
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic                tick_q;

  logic                scan_wrap;
  logic                frame_end;
  logic                accept;
  logic                pwm_on;
  logic                lit;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   an_sel;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SEG7_LZB_EN
  // Walk down from the MSB; a digit stays blank while every digit above it is a bare zero.
  logic lead;
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead     = lead && (disp_data_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
      blank[i] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  assign scan_wrap = (pre_q == PreLast);
  assign frame_end = scan_wrap && (idx_q == IdxLast);
  assign accept    = load && !pend_valid_q;
  assign pwm_on    = (&brightness) || (pwm_q < brightness);
  assign lit       = digit_en[idx_q] && pwm_on && !blank[idx_q];
  assign cur_nib   = disp_data_q[{idx_q, 2'b00} +: 4];
  assign an_sel    = DIGITS'(1) << idx_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      pre_q  <= scan_wrap ? '0 : pre_q + 1'b1;
      pwm_q  <= pwm_q + 1'b1;
      tick_q <= frame_end;
      if (scan_wrap) begin
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end
      // A load taken on the boundary lands in pending only, so it waits a full frame.
      if (frame_end && pend_valid_q) begin
        disp_data_q  <= pend_data_q;
        disp_dp_q    <= pend_dp_q;
        pend_valid_q <= 1'b0;
      end else if (accept) begin
        pend_data_q  <= data;
        pend_dp_q    <= dp_in;
        pend_valid_q <= 1'b1;
      end
      if (lit) begin
        an_q  <= ~an_sel;
        seg_q <= seg_decode(cur_nib);
        dp_q  <= ~disp_dp_q[idx_q];
      end else begin
        an_q  <= '1;
        seg_q <= 7'h7F;
        dp_q  <= 1'b1;
      end
    end
  end

  assign ready      = ~pend_valid_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
